// File: rtl/decode_stage.sv
// decode_stage: two-entry registered instruction-decode stage with valid/ready handshake,
// parametrised immediate extension, optional NOP dropping, flush and a delivered-instruction counter.
`default_nettype none

module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          IMM_SEXT = 1'b1,
  parameter bit          DROP_NOP = 1'b0,
  parameter int unsigned CNTW     = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      opcode,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  output logic [4:0]      rc,
  output logic [4:0]      shamt,
  output logic            shsrc,
  output logic [2:0]      cond,
  output logic [XLEN-1:0] imm17,
  output logic [XLEN-1:0] imm22,
  output logic            is_nop,
  output logic [CNTW-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       main_instr_q;
  logic [XLEN-1:0]   main_pc_q;
  logic [31:0]       skid_instr_q;
  logic [XLEN-1:0]   skid_pc_q;
  logic [CNTW-1:0]   cnt_q;

  logic              push;
  logic              pop;
  logic              in_is_zero;

  // Handshake signals depend on registered state only, so in_ready never sees out_ready.
  always_comb begin
    in_ready   = (state_q != ST_TWO);
    out_valid  = (state_q != ST_EMPTY);
    in_is_zero = (in_instr == 32'd0);
    push       = in_valid & in_ready & ~(DROP_NOP & in_is_zero);
    pop        = out_valid & out_ready;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= 32'd0;
      main_pc_q    <= '0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      // A pop coinciding with flush still counts as delivered.
      if (pop) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      if (flush) begin
        state_q <= ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              main_instr_q <= in_instr;
              main_pc_q    <= in_pc;
              state_q      <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_instr_q <= in_instr;
              main_pc_q    <= in_pc;
            end else if (push) begin
              skid_instr_q <= in_instr;
              skid_pc_q    <= in_pc;
              state_q      <= ST_TWO;
            end else if (pop) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (pop) begin
              main_instr_q <= skid_instr_q;
              main_pc_q    <= skid_pc_q;
              state_q      <= ST_ONE;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
          end
        endcase
      end
    end
  end

  assign out_pc    = main_pc_q;
  assign opcode    = main_instr_q[31:27];
  assign ra        = main_instr_q[26:22];
  assign rb        = main_instr_q[21:17];
  assign rc        = main_instr_q[16:12];
  assign shamt     = main_instr_q[4:0];
  assign shsrc     = main_instr_q[5];
  assign cond      = main_instr_q[2:0];
  assign is_nop    = out_valid & (main_instr_q == 32'd0);
  assign instr_cnt = cnt_q;

  generate
    if (IMM_SEXT) begin : g_sext
      assign imm17 = {{(XLEN-17){main_instr_q[16]}}, main_instr_q[16:0]};
      assign imm22 = {{(XLEN-22){main_instr_q[21]}}, main_instr_q[21:0]};
    end else begin : g_zext
      assign imm17 = {{(XLEN-17){1'b0}}, main_instr_q[16:0]};
      assign imm22 = {{(XLEN-22){1'b0}}, main_instr_q[21:0]};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (sign-extend/keep NOPs/16-bit count and
// zero-extend/drop NOPs/2-bit count) driven by the same random stimulus.
`default_nettype none

module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        ir_w   [2];
  logic        ov_w   [2];
  logic [31:0] pc_w   [2];
  logic [4:0]  op_w   [2];
  logic [4:0]  ra_w   [2];
  logic [4:0]  rb_w   [2];
  logic [4:0]  rc_w   [2];
  logic [4:0]  sh_w   [2];
  logic        shs_w  [2];
  logic [2:0]  cond_w [2];
  logic [31:0] i17_w  [2];
  logic [31:0] i22_w  [2];
  logic        nop_w  [2];
  logic [15:0] cnt_w  [2];
  logic [15:0] cnt0_w;
  logic [1:0]  cnt1_w;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  decode_stage #(.XLEN(32), .IMM_SEXT(1'b1), .DROP_NOP(1'b0), .CNTW(16)) u_dut0 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(ir_w[0]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(ov_w[0]), .out_ready(out_ready), .out_pc(pc_w[0]),
    .opcode(op_w[0]), .ra(ra_w[0]), .rb(rb_w[0]), .rc(rc_w[0]),
    .shamt(sh_w[0]), .shsrc(shs_w[0]), .cond(cond_w[0]),
    .imm17(i17_w[0]), .imm22(i22_w[0]), .is_nop(nop_w[0]), .instr_cnt(cnt0_w)
  );

  decode_stage #(.XLEN(32), .IMM_SEXT(1'b0), .DROP_NOP(1'b1), .CNTW(2)) u_dut1 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(ir_w[1]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(ov_w[1]), .out_ready(out_ready), .out_pc(pc_w[1]),
    .opcode(op_w[1]), .ra(ra_w[1]), .rb(rb_w[1]), .rc(rc_w[1]),
    .shamt(sh_w[1]), .shsrc(shs_w[1]), .cond(cond_w[1]),
    .imm17(i17_w[1]), .imm22(i22_w[1]), .is_nop(nop_w[1]), .instr_cnt(cnt1_w)
  );

  assign cnt_w[0] = cnt0_w;
  assign cnt_w[1] = {14'd0, cnt1_w};

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op, ra, rb, rc, sh;
    logic        shs;
    logic [2:0]  cond;
    logic [31:0] i17, i22;
    logic        nop;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [15:0] mcnt  [2];

  function automatic exp_t make_exp(input logic [31:0] instr, input logic [31:0] pc, input bit sext);
    exp_t e;
    logic [31:0] v;
    e.pc   = pc;
    e.op   = 5'((instr / 32'h0800_0000) % 32);
    e.ra   = 5'((instr / 32'h0040_0000) % 32);
    e.rb   = 5'((instr / 32'h0002_0000) % 32);
    e.rc   = 5'((instr / 32'h0000_1000) % 32);
    e.sh   = 5'(instr % 32);
    e.shs  = 1'((instr / 32) % 2);
    e.cond = 3'(instr % 8);
    v = instr % 32'h0002_0000;
    if (sext && v >= 32'h0001_0000) v = v - 32'h0002_0000;
    e.i17 = v;
    v = instr % 32'h0040_0000;
    if (sext && v >= 32'h0020_0000) v = v - 32'h0040_0000;
    e.i22 = v;
    e.nop = (instr == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, d, $time, act, req);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_out_valid"}, d, 32'(ov_w[d]), 32'd0);
    chk({tag, "_in_ready"},  d, 32'(ir_w[d]), 32'd1);
    chk({tag, "_is_nop"},    d, 32'(nop_w[d]), 32'd0);
    chk({tag, "_cnt"},       d, 32'(cnt_w[d]), 32'd0);
    chk({tag, "_pc"},        d, pc_w[d], 32'd0);
    chk({tag, "_fields"},    d, {7'd0, op_w[d], ra_w[d], rb_w[d], rc_w[d], shs_w[d], cond_w[d]}, 32'd0);
    chk({tag, "_imm"},       d, i17_w[d] | i22_w[d] | 32'(sh_w[d]), 32'd0);
  endtask

  // Monitor and reference model: outputs are compared mid-cycle, then the model
  // advances by the transfer that the coming rising edge will perform.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (!RSTN) begin
        exp_q[d].delete();
        mcnt[d] = 16'd0;
      end else begin
        bit   m_ready, m_valid, do_push, do_pop;
        exp_t h;
        m_ready = (exp_q[d].size() < 2);
        m_valid = (exp_q[d].size() > 0);
        chk("in_ready",  d, 32'(ir_w[d]), 32'(m_ready));
        chk("out_valid", d, 32'(ov_w[d]), 32'(m_valid));
        chk("instr_cnt", d, 32'(cnt_w[d]), 32'(mcnt[d]));
        if (m_valid) begin
          h = exp_q[d][0];
          chk("out_pc", d, pc_w[d], h.pc);
          chk("regs",   d, {17'd0, op_w[d], ra_w[d], rb_w[d]}, {17'd0, h.op, h.ra, h.rb});
          chk("lowflds", d, {23'd0, rc_w[d], sh_w[d], shs_w[d], cond_w[d]}, {23'd0, h.rc, h.sh, h.shs, h.cond});
          chk("imm17",  d, i17_w[d], h.i17);
          chk("imm22",  d, i22_w[d], h.i22);
          chk("is_nop", d, 32'(nop_w[d]), 32'(h.nop));
        end else begin
          chk("is_nop_idle", d, 32'(nop_w[d]), 32'd0);
        end
        do_push = in_valid && m_ready && !(d == 1 && in_instr == 32'd0);
        do_pop  = m_valid && out_ready;
        if (do_pop) mcnt[d] = (d == 0) ? mcnt[d] + 16'd1 : (mcnt[d] + 16'd1) % 16'd4;
        if (flush) begin
          exp_q[d].delete();
        end else begin
          if (do_pop) void'(exp_q[d].pop_front());
          if (do_push) exp_q[d].push_back(make_exp(in_instr, in_pc, d == 0));
        end
      end
    end
  end

  task automatic drive_random();
    int r;
    r = int'($urandom % 10);
    case (r)
      0, 1:    in_instr = 32'd0;
      2:       in_instr = 32'h0001_0000;
      3:       in_instr = 32'h0020_0000;
      4:       in_instr = 32'h0844_2005;
      default: in_instr = $urandom;
    endcase
    in_pc     = $urandom & 32'hFFFF_FFFC;
    in_valid  = ($urandom % 10) < 7;
    out_ready = ($urandom % 10) < 6;
    flush     = ($urandom % 20) == 0;
  endtask

  initial begin
    RSTN = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) chk_zero(d, "reset");

    // Stream: decode example pushed on the first edge after release, then back-to-back.
    RSTN = 1'b1; in_valid = 1'b1; in_instr = 32'h0844_2005; in_pc = 32'h100; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_instr = 32'h0001_0000; in_pc = 32'h104;
    @(posedge CLK); #1;
    in_instr = 32'h0020_0000; in_pc = 32'h108;
    @(posedge CLK); #1;
    in_instr = 32'h0000_0000; in_pc = 32'h10C;

    // Backpressure: A then B stall, then drain.
    @(posedge CLK); #1;
    out_ready = 1'b0; in_instr = 32'h1111_2222; in_pc = 32'h200;
    @(posedge CLK); #1;
    in_instr = 32'h3333_4444; in_pc = 32'h204;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // Flush while full with a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h5555_0001; in_pc = 32'h300;
    @(posedge CLK); #1;
    in_instr = 32'h5555_0002; in_pc = 32'h304;
    @(posedge CLK); #1;
    flush = 1'b1; in_instr = 32'h5555_0003; in_pc = 32'h308;
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;

    repeat (2000) begin
      drive_random();
      @(posedge CLK); #1;
    end

    // Asynchronous reset mid-stream while the buffer is full.
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h7777_8888; in_pc = 32'h400;
    repeat (3) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk_zero(d, "async_rst");
    @(posedge CLK); #1;
    RSTN = 1'b1;

    repeat (800) begin
      drive_random();
      @(posedge CLK); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the RISC toy core, placed between fetch and register read. It accepts 32-bit instructions with their PC over a valid/ready handshake and buffers up to two entries so `in_ready` never depends combinationally on `out_ready`. It presents the split instruction fields, with immediates extended to `XLEN`, to the next stage. Relative to the plain combinational field decoder, it adds parametrised immediate extension, optional NOP squashing, pipeline flush, and a delivered-instruction counter.

## Interface
- `XLEN`, 32: datapath width for PC and extended immediates; must be ≥ 22.
- `IMM_SEXT`, 1: 1 = sign-extend immediates, 0 = zero-extend.
- `DROP_NOP`, 0: 1 = accepted all-zero instructions are discarded instead of buffered.
- `CNTW`, 16: width of the delivered-instruction counter.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTN`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `flush`  in  1  synchronous pipeline flush.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_pc`  out  XLEN  PC of the head entry.
- `opcode`  out  5  head instr[31:27].
- `ra`  out  5  head instr[26:22].
- `rb`  out  5  head instr[21:17].
- `rc`  out  5  head instr[16:12].
- `shamt`  out  5  head instr[4:0].
- `shsrc`  out  1  head instr[5].
- `cond`  out  3  head instr[2:0].
- `imm17`  out  XLEN  head instr[16:0], extended per `IMM_SEXT`.
- `imm22`  out  XLEN  head instr[21:0], extended per `IMM_SEXT`.
- `is_nop`  out  1  `out_valid` AND head instr == 0.
- `instr_cnt`  out  CNTW  count of completed output handshakes; wraps modulo 2^CNTW.

## Operation
- Storage holds two entries: a main register (head, which drives all outputs) and a skid register. Each entry holds the instruction and PC.
- State: EMPTY, ONE, TWO. `out_valid` = (state ≠ EMPTY). `in_ready` = (state ≠ TWO); it is a function of registered state only.
- A push is `in_valid & in_ready`; when `DROP_NOP=1`, a push with `in_instr==0` is suppressed. A pop is `out_valid & out_ready`.
- EMPTY: push → ONE (main ← input).
- ONE: push & pop → ONE (main ← input). Push only → TWO (skid ← input). Pop only → EMPTY.
- TWO: pop → ONE (main ← skid). No push is possible.
- Input order is preserved; no entry is duplicated or lost except through flush or NOP drop.
- Decoding is combinational from the main register. Fields are bit slices. Immediates are sign- or zero-extended from bit 16 or bit 21 respectively.
- `flush` has the highest priority: state → EMPTY. A push in the same cycle is discarded. A pop in the same cycle still completes and increments `instr_cnt`.
- `instr_cnt` increments by 1 on every pop and wraps from 2^CNTW−1 to 0.
- Reset (asynchronous, any time, including mid-transfer): state EMPTY, main and skid ← 0, `instr_cnt` ← 0. Consequently `out_valid`=0, `in_ready`=1, all fields and PC are 0, and `is_nop`=0.

## Timing
- Latency: an instruction pushed at edge N is visible at the outputs after edge N with `out_valid`=1, i.e. 1 cycle.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- `in_ready` falls in the cycle after a push-without-pop in state ONE. It rises in the cycle after the first pop from TWO.
- Output fields are stable while `out_valid & ~out_ready`.
- Reset release: the first push is accepted on the first rising edge with `RSTN`=1.

## Test plan
- Stream: push 0x0844_2005 @pc 0x100 with `out_ready`=1 → next cycle `opcode`=1, `ra`=1, `rb`=2, `rc`=2, `shamt`=5, `shsrc`=0, `cond`=5, `out_pc`=0x100. Back-to-back pushes achieve 1 instr/cycle.
- Backpressure: `out_ready`=0, push A then B → `in_ready`=0 after B. Raise `out_ready` → A then B delivered in order, `instr_cnt`=2.
- Immediates: `in_instr`=0x0001_0000 → `imm17`=0xFFFF_0000 when `IMM_SEXT=1`, 0x0001_0000 when `IMM_SEXT=0`. `in_instr`=0x0020_0000 → `imm22`=0xFFE0_0000 when `IMM_SEXT=1`.
- NOP: push 0x0000_0000 → `is_nop`=1 when `DROP_NOP=0`. With `DROP_NOP=1` the push is accepted, `out_valid` stays 0, and `instr_cnt` is unchanged.
- Flush: in state TWO, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and the flushed entries never appear.
- Reset/wrap: with `CNTW=2`, 5 pops → `instr_cnt`=1. Assert `RSTN`=0 mid-stream → all outputs 0 and `in_ready`=1 immediately, without waiting for a clock edge.
